sumador_segmentado: RTL and testbench
=====================================

Name: sumador_segmentado

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor with carry-in.
- Next generation of the 1-bit half/full adder cells in the CPU datapath.
- Splits the carry chain into STAGES registered segments so the ALU adder path meets timing at wide widths.
- Valid/ready handshake on both sides, backpressure support, add/sub mode, status flags.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be ≥2 and divisible by STAGES.
- STAGES, 4: number of pipeline segments; also the latency in cycles. Legal range 1..WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inValid  in  1  an operation is presented on operandX/operandY/carryIn/sub.
- inReady  out  1  the pipeline accepts the operation this cycle.
- operandX  in  WIDTH  first operand.
- operandY  in  WIDTH  second operand.
- carryIn  in  1  carry input; used only when sub=0.
- sub  in  1  0: X+Y+carryIn; 1: X−Y, computed as X+~Y+1.
- outValid  out  1  result registers hold a valid result.
- outReady  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result.
- carryOut  out  1  carry out of the MSB (for sub: 1 = no borrow).
- overflow  out  1  signed (two's complement) overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset is asynchronous and active-low; rst_n low clears all stage valid bits and data.
  - Reset values: outValid=0, sum=0, carryOut=0, overflow=0, zero=0.
  - inReady=1 while out of reset with the pipeline empty.
- Segmentation: CH = WIDTH/STAGES bits per segment.
  - Stage k (k=0..STAGES−1) adds bits [k*CH +: CH] of X and Y' (Y' = sub ? ~Y : Y), plus the carry registered by stage k−1.
  - Stage 0 carry-in = sub ? 1 : carryIn.
- Each stage register carries:
  - valid bit;
  - result bits produced so far;
  - unconsumed upper chunks of X and Y';
  - chunk carry;
  - sign bits X[WIDTH−1] and Y'[WIDTH−1] for the overflow computation.
- Final stage drives the output registers directly: sum, carryOut, overflow, zero are registered and change only when the pipeline advances.
- Flag definitions:
  - overflow = (X[MSB] == Y'[MSB]) && (sum[MSB] != X[MSB]).
  - zero = (sum == 0).
- Latency: an operation accepted at rising edge N has outValid=1 after edge N+STAGES, provided no stall occurs.
- Throughput: one operation per cycle.
- Handshake and stall:
  - advance = !outValid || outReady.
  - inReady = advance (combinational).
  - When advance=0, every stage register and every output holds its value, and sum/flags stay stable while outValid=1.
  - A transfer occurs on an edge with inValid && inReady.
  - When inValid=0 and advance=1, a bubble (valid=0) enters stage 0.
  - Simultaneous accept at the input and consume at the output in the same cycle is legal; no bubble is inserted.
  - Operand inputs are ignored when inValid=0.
- Ordering: results leave strictly in acceptance order; no drop or duplication under any outReady pattern.
- Reset mid-operation discards all in-flight operations; none reappear after reset release.
- Width rules: all arithmetic is unsigned modulo 2^WIDTH; the carry is the (WIDTH+1)th bit.
- STAGES=1: a single registered full WIDTH-bit adder with latency 1.

Optional Feature:
- Macro: SUMADOR_FLAGS_EN.
- Defined: overflow and zero are computed and registered as above.
- Undefined:
  - overflow and zero are tied to 0 and their logic and pipeline fields are not synthesised;
  - sum, carryOut and handshake behaviour are identical.
- Port list is the same in both builds.

Test Plan (WIDTH=16, STAGES=4, SUMADOR_FLAGS_EN defined):
- Latency and carry ripple: reset, then one op X=0x00FF, Y=0x0001, carryIn=0, sub=0 → outValid rises exactly 4 edges after accept; sum=0x0100, carryOut=0, overflow=0, zero=0.
- Full wrap: X=0xFFFF, Y=0x0000, carryIn=1 → sum=0x0000, carryOut=1, zero=1, overflow=0.
- Signed overflow: X=0x7FFF, Y=0x0001, carryIn=0 → sum=0x8000, carryOut=0, overflow=1.
- Subtraction: X=0x0005, Y=0x0007, sub=1, carryIn=1 (must be ignored) → sum=0xFFFE, carryOut=0, overflow=0. Then X=0x8000, Y=0x0001, sub=1 → sum=0x7FFF, carryOut=1, overflow=1.
- Backpressure stream: 10 random back-to-back ops with outReady=0 for 3 consecutive cycles mid-stream → inReady=0 during the stall; sum/flags stable while stalled; all 10 results match the reference model in order.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle before any result → outValid=0 immediately and no stale result afterwards. Then op 0x1234+0x1111 → sum=0x2345 after 4 cycles.

Source files
------------

// File: rtl/sumador_segmentado.sv
// sumador_segmentado: pipelined WIDTH-bit adder/subtractor with carry-in,
// valid/ready handshake and status flags.
//
// The carry chain is cut into STAGES segments of CH = WIDTH/STAGES bits.
// An input register captures X, Y' (Y' = sub ? ~Y : Y) and the initial carry.
// Each stage then adds one chunk and registers the result, so an operation
// accepted on edge N is on the outputs after edge N+STAGES. The last stage
// writes the output registers directly.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   inValid   operation presented on operandX/operandY/carryIn/sub
//   inReady   pipeline accepts the operation this cycle
//   operandX  first operand  [WIDTH]
//   operandY  second operand [WIDTH]
//   carryIn   carry input, used only when sub=0
//   sub       0: X+Y+carryIn, 1: X-Y as X+~Y+1
//   outValid  output registers hold a valid result
//   outReady  consumer accepts the result this cycle
//   sum       result [WIDTH]
//   carryOut  carry out of the MSB (subtract: 1 = no borrow)
//   overflow  signed overflow
//   zero      sum == 0
//
// Build option: define SUMADOR_FLAGS_EN to compute overflow and zero;
// otherwise both outputs are tied to 0 and their logic is omitted.
module sumador_segmentado #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] operandX,
   input  logic [WIDTH-1:0] operandY,
   input  logic             carryIn,
   input  logic             sub,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] sum,
   output logic             carryOut,
   output logic             overflow,
   output logic             zero
);
   localparam int CH = WIDTH / STAGES;
   localparam logic [WIDTH-1:0] M = WIDTH'({CH{1'b1}});
   // Entry k is the register feeding stage k; entry STAGES is the output
   // register. r_x is rewritten in place: chunks below k hold sum bits,
   // chunks from k up still hold X.
   logic [STAGES:0]                r_v;
   logic [STAGES:0]                r_c;
   logic [STAGES:0][WIDTH-1:0]     r_x;
   logic [STAGES-1:0][WIDTH-1:0]   r_y;
   logic [STAGES-1:0][CH:0]        w_add;
   logic [STAGES-1:0][WIDTH-1:0]   w_x;
   logic                           w_adv;
   assign w_adv    = !r_v[STAGES] || outReady;
   assign inReady  = w_adv;
   assign outValid = r_v[STAGES];
   assign sum      = r_x[STAGES];
   assign carryOut = r_c[STAGES];
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign w_add[k] = {1'b0, r_x[k][k*CH +: CH]} + {1'b0, r_y[k][k*CH +: CH]} + {{CH{1'b0}}, r_c[k]};
      assign w_x[k]   = (r_x[k] & ~(M << (k*CH))) | (WIDTH'(w_add[k][CH-1:0]) << (k*CH));
   end
   // Data fields only load behind a valid bit so bubbles never disturb the
   // held result on sum/carryOut.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
         r_c <= '0;
         r_x <= '0;
         r_y <= '0;
      end else if (w_adv) begin
         r_v[0] <= inValid;
         if (inValid) begin
            r_x[0] <= operandX;
            r_y[0] <= sub ? ~operandY : operandY;
            r_c[0] <= sub | carryIn;
         end
         for (int k = 0; k < STAGES; k++) begin
            r_v[k+1] <= r_v[k];
            if (r_v[k]) begin
               r_x[k+1] <= w_x[k];
               r_c[k+1] <= w_add[k][CH];
            end
         end
         for (int k = 0; k < STAGES-1; k++)
            if (r_v[k]) r_y[k+1] <= r_y[k];
      end
   end
`ifdef SUMADOR_FLAGS_EN
   logic r_ov;
   logic r_z;
   // The top chunk of r_x/r_y at the last stage still holds the original
   // X and Y' sign bits, so no separate sign fields are needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ov <= 1'b0;
         r_z  <= 1'b0;
      end else if (w_adv && r_v[STAGES-1]) begin
         r_ov <= (r_x[STAGES-1][WIDTH-1] == r_y[STAGES-1][WIDTH-1]) &&
                 (w_x[STAGES-1][WIDTH-1] != r_x[STAGES-1][WIDTH-1]);
         r_z  <= w_x[STAGES-1] == '0;
      end
   end
   assign overflow = r_ov;
   assign zero     = r_z;
`else
   assign overflow = 1'b0;
   assign zero     = 1'b0;
`endif
endmodule

// File: tb/tb_sumador_segmentado.sv
// tb_sumador_segmentado: directed and table-driven checks of sumador_segmentado (16 bits, 4 stages).
module tb_sumador_segmentado;
   localparam int W = 16;
`ifdef SUMADOR_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, inValid = 1'b0, outReady = 1'b1, carryIn = 1'b0, sub = 1'b0;
   logic inReady, outValid, carryOut, overflow, zero;
   logic [W-1:0] operandX = '0, operandY = '0, sum;
   int checks = 0, failures = 0;
   typedef struct packed {
      logic [W-1:0] x, y;
      logic         cin, sb;
      logic [W-1:0] s;
      logic         co, ov, z;
   } vec_t;
   vec_t tbl [9];
   logic [W-1:0] sx [10], sy [10];
   logic         sc [10], ss [10];
   logic [18:0]  q [$];

   always #5 clk = ~clk;

   sumador_segmentado #(.WIDTH(W), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
      .operandX(operandX), .operandY(operandY), .carryIn(carryIn), .sub(sub),
      .outValid(outValid), .outReady(outReady), .sum(sum), .carryOut(carryOut),
      .overflow(overflow), .zero(zero));

   // Reference: {overflow, zero, carryOut, sum}
   function automatic logic [18:0] model(input logic [W-1:0] x, y, input logic c, s);
      logic [W-1:0] yp;
      logic [W:0]   t;
      logic         ov, z;
      yp = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, yp} + {{W{1'b0}}, (s ? 1'b1 : c)};
      ov = (x[W-1] == yp[W-1]) && (t[W-1] != x[W-1]);
      z  = t[W-1:0] == '0;
      return {ov & FL, z & FL, t[W], t[W-1:0]};
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input vec_t v);
      int n;
      operandX = v.x; operandY = v.y; carryIn = v.cin; sub = v.sb;
      chk("one_inReady", inReady, 1);
      inValid = 1'b1;
      step();
      inValid = 1'b0;
      n = 0;
      while (!outValid && n < 20) begin
         step();
         n++;
      end
      chk("latency", n, 4);
      chk("sum", sum, v.s);
      chk("carryOut", carryOut, v.co);
      chk("overflow", overflow, v.ov & FL);
      chk("zero", zero, v.z & FL);
      step();
      chk("drained", outValid, 0);
   endtask

   initial begin
      int sent, got, cyc, last, bad;
      logic [18:0] e;
      //          x        y        cin   sb    sum      co    ov    z
      tbl[0] = {16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
      tbl[1] = {16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      tbl[2] = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      tbl[3] = {16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      tbl[4] = {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      tbl[5] = {16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
      tbl[6] = {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      tbl[7] = {16'h00AA, 16'h00AA, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      tbl[8] = {16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         sx[i] = 16'($urandom);
         sy[i] = 16'($urandom);
         sc[i] = 1'($urandom);
         ss[i] = 1'($urandom);
      end

      repeat (2) step();
      chk("rst_outValid", outValid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_carryOut", carryOut, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_zero", zero, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_inReady", inReady, 1);

      for (int i = 0; i < 9; i++) run_one(tbl[i]);

      // Back-to-back stream with a three-cycle consumer stall
      sent = 0; got = 0; cyc = 0; last = -1;
      while (got < 10 && cyc < 100) begin
         outReady = !(cyc >= 6 && cyc <= 8);
         inValid  = sent < 10;
         if (sent < 10) begin
            operandX = sx[sent]; operandY = sy[sent]; carryIn = sc[sent]; sub = ss[sent];
         end
         #1;
         if (!outReady) begin
            chk("stall_inReady", inReady, 0);
            chk("stall_outValid", outValid, 1);
            if (q.size() > 0) chk("stall_hold", {overflow, zero, carryOut, sum}, q[0]);
         end
         if (outValid && outReady) begin
            if (q.size() == 0) chk("stream_extra", 1, 0);
            else begin
               e = q.pop_front();
               chk("stream_result", {overflow, zero, carryOut, sum}, e);
            end
            got++;
            last = cyc;
         end
         if (inValid && inReady) begin
            q.push_back(model(operandX, operandY, carryIn, sub));
            sent++;
         end
         step();
         cyc++;
      end
      inValid = 1'b0;
      outReady = 1'b1;
      chk("stream_count", got, 10);
      chk("stream_end_cycle", last, 17);

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         operandX = 16'(16'h1000 * (i + 1)); operandY = 16'h0101; carryIn = 1'b0; sub = 1'b0;
         inValid = 1'b1;
         step();
      end
      inValid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outValid", outValid, 0);
      chk("mid_rst_sum", sum, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      repeat (8) begin
         step();
         if (outValid) bad++;
      end
      chk("no_stale", bad, 0);
      run_one(tbl[5]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
